mem_copy_initiator: RTL
=======================

// Module: mem_copy_initiator
// PURPOSE
//  Bus-master copy engine on the CPU memory interface (mem_cmd/mem_addr/write_data/read_data).
//  Copies a block of 16-bit words from a source to a destination in the 256-word RAM space
//  (mem_addr[8]=0) using MREAD/MWRITE. Muxed with the CPU onto the same interface by the top level.
//  It is the initiator counterpart of the RAM + address-decode responder and honours its 1-cycle read latency.
// PARAMETERS
//  ADDR_W  9   memory address width; bit ADDR_W-1 set selects I/O space, which is illegal here
//  DATA_W  16  word width
//  LEN_W   8   transfer length width, in words
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       request; sampled only in IDLE
//  src_addr    in   ADDR_W  first source word address; sampled with start
//  dst_addr    in   ADDR_W  first destination word address; sampled with start
//  length      in   LEN_W   word count; 0 means no transfer
//  busy        out  1       high in RD, RDW and WR
//  done        out  1       1-cycle pulse in DONE
//  err         out  1       range error on the last request; held until the next accepted start
//  mem_cmd     out  2       MNONE=00, MREAD=01, MWRITE=10
//  mem_addr    out  ADDR_W  memory address
//  write_data  out  DATA_W  store data, valid with MWRITE
//  read_data   in   DATA_W  load data; valid in the cycle after an MREAD issue while MREAD is held
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, mem_cmd=MNONE, mem_addr=0, write_data=0, busy=0, done=0, err=0.
//  - Takes effect immediately, mid-transfer included. No further MREAD/MWRITE is issued.
//  - Any word not yet written is lost. No partial-word write.
//  Outputs are decoded from registered state and counters only. No combinational path from inputs.
//  FSM:
//  - IDLE:
//    - start=1, length=0 -> DONE (err=0).
//    - start=1, range illegal -> DONE (err=1).
//    - start=1 otherwise -> latch src/dst/length, clear err, -> RD.
//  - RD: mem_cmd=MREAD, mem_addr=src_ptr -> RDW.
//  - RDW: hold mem_cmd=MREAD and the same mem_addr. At the clock edge capture read_data into write_data -> WR.
//  - WR: mem_cmd=MWRITE, mem_addr=dst_ptr, write_data=captured word. At the edge:
//    - src_ptr++, dst_ptr++, remaining--.
//    - remaining becomes 0 -> DONE, else -> RD.
//  - DONE: done=1, mem_cmd=MNONE, busy=0 -> IDLE.
//  Range rule: illegal if src_addr+length-1 > 255 or dst_addr+length-1 > 255.
//  - Computed in ADDR_W+1 bits so there is no wrap.
//  - Consequently mem_addr[8] is never 1 and pointers never wrap.
//  Timing: start sampled at edge 0.
//  - Word k (0-based) occupies cycles 3k+1 (RD), 3k+2 (RDW) and 3k+3 (WR).
//  - done is high in cycle 3N+1. Zero-length or error requests give done in cycle 1.
//  start outside IDLE (including DONE) is ignored. Inputs need not be held after acceptance.
//  Overlap: strictly ascending forward copy, no overlap correction.
//  - With dst>src inside the source window, already-overwritten words are re-read. This is defined behaviour.
//  mem_cmd is MNONE in IDLE and DONE. mem_addr and write_data keep their last values there.
// TESTING
//  T1 RAM[0x010..0x013]=A1,B2,C3,D4. start, src=0x010, dst=0x080, len=4.
//     -> RAM[0x080..0x083]=A1,B2,C3,D4; done in cycle 13; mem_cmd sequence R,R,W x4; err=0.
//  T2 len=0 -> done in cycle 1; mem_cmd stays MNONE throughout; RAM unchanged.
//  T3 src=0x0FE, len=4 -> err=1, done in cycle 1, no MREAD/MWRITE.
//     A following legal start clears err.
//  T4 len=3, pull reset low during the WR of word 1 (cycle 6).
//     -> mem_cmd=MNONE at once; RAM dst+0 written, dst+1 and dst+2 untouched; busy=0.
//  T5 Pulse start with new args in cycle 2 of a len=2 copy.
//     -> ignored; only the first copy is performed; exactly one done pulse.
//  T6 Overlap: src=0x020, dst=0x021, len=3, RAM[0x020]=5.
//     -> RAM[0x021..0x023]=5,5,5 (forward-copy semantics).

Source files
------------

// File: rtl/mem_copy_initiator.sv
// Bus-master block copy engine for the CPU memory interface: copies words from src to dst
// within RAM space using MREAD/MWRITE, honouring the responder's 1-cycle read latency.
module mem_copy_initiator #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Highest legal word address: everything below the I/O-select bit.
  localparam logic [ADDR_W:0] RAM_TOP = (ADDR_W+1)'((1 << (ADDR_W-1)) - 1);

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;

  // Last word of the window, computed one bit wider so an overflow cannot wrap back into RAM.
  function automatic logic window_illegal(input logic [ADDR_W-1:0] base,
                                          input logic [LEN_W-1:0]  len);
    logic [ADDR_W:0] last;
    last = {1'b0, base} + (ADDR_W+1)'(len) - (ADDR_W+1)'(1);
    return last > RAM_TOP;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_cmd    <= MNONE;
      mem_addr   <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              err   <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (window_illegal(src_addr, length) ||
                         window_illegal(dst_addr, length)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err       <= 1'b0;
              src_ptr   <= src_addr;
              dst_ptr   <= dst_addr;
              remaining <= length;
              mem_cmd   <= MREAD;
              mem_addr  <= src_addr;
              busy      <= 1'b1;
              state     <= RD;
            end
          end
        end
        RD: begin
          state <= RDW;
        end
        RDW: begin
          // The responder's data is valid now, one cycle after the read was issued.
          write_data <= read_data;
          mem_cmd    <= MWRITE;
          mem_addr   <= dst_ptr;
          state      <= WR;
        end
        WR: begin
          src_ptr   <= src_ptr + ADDR_W'(1);
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            mem_cmd <= MNONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            mem_cmd  <= MREAD;
            mem_addr <= src_ptr + ADDR_W'(1);
            state    <= RD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_cmd <= MNONE;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
